// File: rtl/axi_addr_remap_pkg.sv
// Shared types and helpers for the registered AXI4 address-remap stage.
// Holds the rule template, AXI channel/request/response structs, the
// statistics counter width and the match/translate function find_rule().
// Optional build macro used by the users of this package: AXI_ADDR_REMAP_STATS_EN.
package axi_addr_remap_pkg;

    localparam int unsigned SLV_AW    = 64;
    localparam int unsigned MST_AW    = 48;
    localparam int unsigned ID_W      = 4;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned USER_W    = 1;
    localparam int unsigned CNT_W     = 32;
    // Upper bound on table size; find_rule scans a padded table of this depth.
    localparam int unsigned MAX_RULES = 16;
    localparam int unsigned IDX_W     = $clog2(MAX_RULES);

    typedef struct packed {
        logic [SLV_AW-1:0] base;
        logic [SLV_AW-1:0] mask;
        logic [MST_AW-1:0] target;
    } rule_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [MST_AW-1:0] mapped;
    } match_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [SLV_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } slv_aw_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [MST_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } mst_aw_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [SLV_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } slv_ar_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [MST_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } mst_ar_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
        logic [USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        slv_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        slv_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } slv_req_t;

    typedef struct packed {
        mst_aw_chan_t aw;
        logic         aw_valid;
        w_chan_t      w;
        logic         w_valid;
        logic         b_ready;
        mst_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } mst_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

    // Truncate or zero-extend a slave address onto the master width.
    function automatic logic [MST_AW-1:0] fit_addr(input logic [SLV_AW-1:0] addr);
        return MST_AW'(addr);
    endfunction

    // Lowest-index matching rule wins; entries at or above num are ignored.
    function automatic match_t find_rule(input logic [SLV_AW-1:0]     addr,
                                         input rule_t [MAX_RULES-1:0] rules,
                                         input int                    num);
        match_t res;
        res        = '0;
        res.mapped = fit_addr(addr);
        // Scan downwards so the last assignment comes from the lowest index.
        for (int i = int'(MAX_RULES) - 1; i >= 0; i--) begin
            if (i < num && (addr & rules[i].mask) == (rules[i].base & rules[i].mask)) begin
                res.hit    = 1'b1;
                res.idx    = IDX_W'(i);
                res.mapped = rules[i].target | fit_addr(addr & ~rules[i].mask);
            end
        end
        return res;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/axi_addr_remap_chan.sv
// One AW-or-AR channel of the remap stage: translate on accept, hold the
// translated beat in a one-entry full-throughput register.
// Optional build macro: AXI_ADDR_REMAP_STATS_EN adds hit/miss counters.
module axi_addr_remap_chan
    import axi_addr_remap_pkg::*;
#(
    parameter int unsigned NumRules     = 4,
    parameter int unsigned SlvAddrWidth = SLV_AW,
    parameter int unsigned MstAddrWidth = MST_AW,
    parameter type         slv_chan_t   = slv_aw_chan_t,
    parameter type         mst_chan_t   = mst_aw_chan_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  rule_t [NumRules-1:0]  rules_i,
    input  slv_chan_t             slv_chan_i,
    input  logic                  slv_valid_i,
    output logic                  slv_ready_o,
    output mst_chan_t             mst_chan_o,
    output logic                  mst_valid_o,
    input  logic                  mst_ready_i,
    output logic                  miss_o
`ifdef AXI_ADDR_REMAP_STATS_EN
    ,
    output logic [CNT_W-1:0]      hit_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o
`endif
);

    rule_t [MAX_RULES-1:0]   rules_pad;
    logic [SlvAddrWidth-1:0] slv_addr;
    logic [MstAddrWidth-1:0] mapped;
    match_t                  match;
    logic                    hit;
    logic                    accept;
    logic                    full_q;
    mst_chan_t               chan_d;
    mst_chan_t               chan_q;

    // Widen the table to the fixed depth find_rule scans; spare entries stay zero.
    always_comb begin
        rules_pad = '0;
        for (int i = 0; i < int'(NumRules); i++) begin
            rules_pad[i] = rules_i[i];
        end
    end

    assign slv_addr = slv_chan_i.addr;
    assign match    = find_rule(SLV_AW'(slv_addr), rules_pad, int'(NumRules));
    assign mapped   = MstAddrWidth'(match.mapped);
    // Padding entries are never scanned, so a hit always lands inside the table.
    assign hit      = match.hit && (int'(match.idx) < int'(NumRules));

    // Slot is free when empty or when the held beat leaves this cycle.
    assign slv_ready_o = ~full_q | mst_ready_i;
    assign accept      = slv_valid_i & slv_ready_o;
    assign mst_valid_o = full_q;
    assign mst_chan_o  = chan_q;
    assign miss_o      = accept & ~hit & ~rst_i;

    // Build the master-side beat: every field copied, address replaced.
    always_comb begin
        chan_d        = '0;
        chan_d.id     = slv_chan_i.id;
        chan_d.addr   = mapped;
        chan_d.len    = slv_chan_i.len;
        chan_d.size   = slv_chan_i.size;
        chan_d.burst  = slv_chan_i.burst;
        chan_d.lock   = slv_chan_i.lock;
        chan_d.cache  = slv_chan_i.cache;
        chan_d.prot   = slv_chan_i.prot;
        chan_d.qos    = slv_chan_i.qos;
        chan_d.region = slv_chan_i.region;
        chan_d.user   = slv_chan_i.user;
    end

    // Holding register: load on accept (also when popping), drop on a bare pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            chan_q <= '0;
        end else if (accept) begin
            full_q <= 1'b1;
            chan_q <= chan_d;
        end else if (mst_ready_i) begin
            full_q <= 1'b0;
        end
    end

`ifdef AXI_ADDR_REMAP_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    // Saturating hit/miss counters, one step per accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
            else     miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: rtl/axi_addr_remap_reg.sv
// Registered AXI4 address-translation stage. AW and AR each go through a
// remap channel (translate + one-entry register); W, B and R pass through.
// Optional build macro: AXI_ADDR_REMAP_STATS_EN adds per-channel hit/miss counters.
module axi_addr_remap_reg
    import axi_addr_remap_pkg::*;
#(
    parameter int unsigned NumRules     = 4,
    parameter int unsigned SlvAddrWidth = SLV_AW,
    parameter int unsigned MstAddrWidth = MST_AW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  rule_t [NumRules-1:0] rules_i,
    input  slv_req_t             slv_req_i,
    output axi_resp_t            slv_resp_o,
    output mst_req_t             mst_req_o,
    input  axi_resp_t            mst_resp_i,
    output logic                 aw_miss_o,
    output logic                 ar_miss_o
`ifdef AXI_ADDR_REMAP_STATS_EN
    ,
    output logic [CNT_W-1:0]     aw_hit_cnt_o,
    output logic [CNT_W-1:0]     ar_hit_cnt_o,
    output logic [CNT_W-1:0]     aw_miss_cnt_o,
    output logic [CNT_W-1:0]     ar_miss_cnt_o
`endif
);

    mst_aw_chan_t aw_chan;
    mst_ar_chan_t ar_chan;
    logic         aw_valid;
    logic         ar_valid;
    logic         aw_ready;
    logic         ar_ready;

    axi_addr_remap_chan #(
        .NumRules     (NumRules),
        .SlvAddrWidth (SlvAddrWidth),
        .MstAddrWidth (MstAddrWidth),
        .slv_chan_t   (slv_aw_chan_t),
        .mst_chan_t   (mst_aw_chan_t)
    ) u_aw (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rules_i     (rules_i),
        .slv_chan_i  (slv_req_i.aw),
        .slv_valid_i (slv_req_i.aw_valid),
        .slv_ready_o (aw_ready),
        .mst_chan_o  (aw_chan),
        .mst_valid_o (aw_valid),
        .mst_ready_i (mst_resp_i.aw_ready),
        .miss_o      (aw_miss_o)
`ifdef AXI_ADDR_REMAP_STATS_EN
        ,
        .hit_cnt_o   (aw_hit_cnt_o),
        .miss_cnt_o  (aw_miss_cnt_o)
`endif
    );

    axi_addr_remap_chan #(
        .NumRules     (NumRules),
        .SlvAddrWidth (SlvAddrWidth),
        .MstAddrWidth (MstAddrWidth),
        .slv_chan_t   (slv_ar_chan_t),
        .mst_chan_t   (mst_ar_chan_t)
    ) u_ar (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rules_i     (rules_i),
        .slv_chan_i  (slv_req_i.ar),
        .slv_valid_i (slv_req_i.ar_valid),
        .slv_ready_o (ar_ready),
        .mst_chan_o  (ar_chan),
        .mst_valid_o (ar_valid),
        .mst_ready_i (mst_resp_i.ar_ready),
        .miss_o      (ar_miss_o)
`ifdef AXI_ADDR_REMAP_STATS_EN
        ,
        .hit_cnt_o   (ar_hit_cnt_o),
        .miss_cnt_o  (ar_miss_cnt_o)
`endif
    );

    // Master request: registered AW/AR, everything else straight through.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw       = aw_chan;
        mst_req_o.aw_valid = aw_valid;
        mst_req_o.ar       = ar_chan;
        mst_req_o.ar_valid = ar_valid;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    // Slave response mirrors the master except for the locally owned address readies.
    always_comb begin
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.ar_ready = ar_ready;
    end

endmodule

// File: tb/tb_axi_addr_remap_reg.sv
// Directed self-checking bench for axi_addr_remap_reg. Inputs change 1 time
// unit after the rising edge; outputs are sampled on the falling edge.
// Build with AXI_ADDR_REMAP_STATS_EN to also exercise the counters.
module tb_axi_addr_remap_reg;
    import axi_addr_remap_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    rule_t [3:0]     rules;
    slv_req_t        slv_req;
    axi_resp_t       slv_resp;
    mst_req_t        mst_req;
    axi_resp_t       mst_resp;
    logic            aw_miss;
    logic            ar_miss;
`ifdef AXI_ADDR_REMAP_STATS_EN
    logic [31:0]     aw_hit_cnt, ar_hit_cnt, aw_miss_cnt, ar_miss_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    axi_addr_remap_reg #(.NumRules(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rules_i       (rules),
        .slv_req_i     (slv_req),
        .slv_resp_o    (slv_resp),
        .mst_req_o     (mst_req),
        .mst_resp_i    (mst_resp),
        .aw_miss_o     (aw_miss),
        .ar_miss_o     (ar_miss)
`ifdef AXI_ADDR_REMAP_STATS_EN
        ,
        .aw_hit_cnt_o  (aw_hit_cnt),
        .ar_hit_cnt_o  (ar_hit_cnt),
        .aw_miss_cnt_o (aw_miss_cnt),
        .ar_miss_cnt_o (ar_miss_cnt)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 64'h8000_1234;
        repeat (3) begin
            @(negedge clk);
            total++; if (mst_req.aw_valid !== 1'b0) $display("FAIL reset_aw_valid: got %0b want 0", mst_req.aw_valid); else passed++;
            total++; if (mst_req.ar_valid !== 1'b0) $display("FAIL reset_ar_valid: got %0b want 0", mst_req.ar_valid); else passed++;
            total++; if (aw_miss !== 1'b0) $display("FAIL reset_aw_miss: got %0b want 0", aw_miss); else passed++;
        end
        total++; if (mst_req.aw.addr !== 48'h0) $display("FAIL reset_aw_payload: got %h want 0", mst_req.aw.addr); else passed++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (mst_req.aw_valid !== 1'b0) $display("FAIL first_accept_valid: got %0b want 0", mst_req.aw_valid); else passed++;
        total++; if (slv_resp.aw_ready !== 1'b1) $display("FAIL first_accept_ready: got %0b want 1", slv_resp.aw_ready); else passed++;
        next_cycle();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        total++; if (mst_req.aw_valid !== 1'b1) $display("FAIL first_beat_valid: got %0b want 1", mst_req.aw_valid); else passed++;
        total++; if (mst_req.aw.addr !== 48'h1_2000_1234) $display("FAIL first_beat_addr: got %h want 120001234", mst_req.aw.addr); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (mst_req.aw_valid !== 1'b0) $display("FAIL first_beat_pop: got %0b want 0", mst_req.aw_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_aw_hit();
        slv_req.aw          = '0;
        slv_req.aw.id       = 4'd5;
        slv_req.aw.addr     = 64'h8000_1234;
        slv_req.aw.len      = 8'd3;
        slv_req.aw.burst    = 2'b01;
        slv_req.aw_valid    = 1'b1;
        @(negedge clk);
        total++; if (aw_miss !== 1'b0) $display("FAIL aw_hit_miss: got %0b want 0", aw_miss); else passed++;
        next_cycle();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        total++; if (mst_req.aw.addr !== 48'h1_2000_1234) $display("FAIL aw_hit_addr: got %h want 120001234", mst_req.aw.addr); else passed++;
        total++; if (mst_req.aw.id !== 4'd5) $display("FAIL aw_hit_id: got %0d want 5", mst_req.aw.id); else passed++;
        total++; if (mst_req.aw.len !== 8'd3) $display("FAIL aw_hit_len: got %0d want 3", mst_req.aw.len); else passed++;
        total++; if (mst_req.aw.burst !== 2'b01) $display("FAIL aw_hit_burst: got %0d want 1", mst_req.aw.burst); else passed++;
        total++; if (aw_miss !== 1'b0) $display("FAIL aw_hit_miss_late: got %0b want 0", aw_miss); else passed++;
        next_cycle();
    endtask

    task automatic test_ar_miss();
        slv_req.ar       = '0;
        slv_req.ar.id    = 4'd2;
        slv_req.ar.addr  = 64'h4000_0010;
        slv_req.ar_valid = 1'b1;
        @(negedge clk);
        total++; if (ar_miss !== 1'b1) $display("FAIL ar_miss_pulse: got %0b want 1", ar_miss); else passed++;
        next_cycle();
        slv_req.ar_valid = 1'b0;
        @(negedge clk);
        total++; if (ar_miss !== 1'b0) $display("FAIL ar_miss_width: got %0b want 0", ar_miss); else passed++;
        total++; if (mst_req.ar_valid !== 1'b1) $display("FAIL ar_miss_valid: got %0b want 1", mst_req.ar_valid); else passed++;
        total++; if (mst_req.ar.addr !== 48'h0000_4000_0010) $display("FAIL ar_miss_addr: got %h want 40000010", mst_req.ar.addr); else passed++;
        total++; if (mst_req.ar.id !== 4'd2) $display("FAIL ar_miss_id: got %0d want 2", mst_req.ar.id); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (mst_req.ar_valid !== 1'b0) $display("FAIL ar_miss_pop: got %0b want 0", mst_req.ar_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_stall();
        mst_resp.aw_ready = 1'b0;
        slv_req.aw.addr   = 64'hC000_0040;
        slv_req.aw_valid  = 1'b1;
        @(negedge clk);
        total++; if (slv_resp.aw_ready !== 1'b1) $display("FAIL stall_empty_ready: got %0b want 1", slv_resp.aw_ready); else passed++;
        next_cycle();
        slv_req.aw.addr = 64'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (mst_req.aw.addr !== 48'h3_0000_0040) $display("FAIL stall_hold_addr[%0d]: got %h want 300000040", i, mst_req.aw.addr); else passed++;
            total++; if (mst_req.aw_valid !== 1'b1) $display("FAIL stall_hold_valid[%0d]: got %0b want 1", i, mst_req.aw_valid); else passed++;
            total++; if (slv_resp.aw_ready !== 1'b0) $display("FAIL stall_slv_ready[%0d]: got %0b want 0", i, slv_resp.aw_ready); else passed++;
            next_cycle();
        end
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        total++; if (slv_resp.aw_ready !== 1'b1) $display("FAIL stall_release_ready: got %0b want 1", slv_resp.aw_ready); else passed++;
        total++; if (mst_req.aw.addr !== 48'h3_0000_0040) $display("FAIL stall_release_addr: got %h want 300000040", mst_req.aw.addr); else passed++;
        next_cycle();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        total++; if (mst_req.aw_valid !== 1'b1) $display("FAIL b2b_valid: got %0b want 1", mst_req.aw_valid); else passed++;
        total++; if (mst_req.aw.addr !== 48'h1_2000_0008) $display("FAIL b2b_addr: got %h want 120000008", mst_req.aw.addr); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (mst_req.aw_valid !== 1'b0) $display("FAIL b2b_drain: got %0b want 0", mst_req.aw_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_priority();
        slv_req.ar       = '0;
        slv_req.ar.addr  = 64'h8000_0000;
        slv_req.ar_valid = 1'b1;
        @(negedge clk);
        total++; if (ar_miss !== 1'b0) $display("FAIL prio_miss: got %0b want 0", ar_miss); else passed++;
        next_cycle();
        slv_req.ar_valid = 1'b0;
        @(negedge clk);
        total++; if (mst_req.ar.addr !== 48'h1_2000_0000) $display("FAIL prio_addr: got %h want 120000000", mst_req.ar.addr); else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                slv_req.ar_valid = 1'b1;
                slv_req.ar.addr  = 64'h8000_0000 + 64'(i * 16);
                slv_req.ar.id    = 4'(i);
            end else begin
                slv_req.ar_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                total++; if (mst_req.ar_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %0b want 1", i - 1, mst_req.ar_valid); else passed++;
                total++; if (mst_req.ar.addr !== 48'h1_2000_0000 + 48'((i - 1) * 16)) $display("FAIL stream_addr[%0d]: got %h want %h", i - 1, mst_req.ar.addr, 48'h1_2000_0000 + 48'((i - 1) * 16)); else passed++;
                total++; if (mst_req.ar.id !== 4'(i - 1)) $display("FAIL stream_id[%0d]: got %0d want %0d", i - 1, mst_req.ar.id, i - 1); else passed++;
            end
            if (i < 16) begin
                total++; if (slv_resp.ar_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %0b want 1", i, slv_resp.ar_ready); else passed++;
            end
            next_cycle();
        end
        @(negedge clk);
        total++; if (mst_req.ar_valid !== 1'b0) $display("FAIL stream_drain: got %0b want 0", mst_req.ar_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_concurrent();
        slv_req.aw       = '0;
        slv_req.ar       = '0;
        slv_req.aw.addr  = 64'h4000_0000;
        slv_req.ar.addr  = 64'hC000_0000;
        slv_req.aw_valid = 1'b1;
        slv_req.ar_valid = 1'b1;
        @(negedge clk);
        total++; if (aw_miss !== 1'b1) $display("FAIL conc_aw_miss: got %0b want 1", aw_miss); else passed++;
        total++; if (ar_miss !== 1'b0) $display("FAIL conc_ar_miss: got %0b want 0", ar_miss); else passed++;
        next_cycle();
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b0;
        @(negedge clk);
        total++; if (mst_req.aw.addr !== 48'h4000_0000) $display("FAIL conc_aw_addr: got %h want 40000000", mst_req.aw.addr); else passed++;
        total++; if (mst_req.ar.addr !== 48'h3_0000_0000) $display("FAIL conc_ar_addr: got %h want 300000000", mst_req.ar.addr); else passed++;
        total++; if ({mst_req.aw_valid, mst_req.ar_valid} !== 2'b11) $display("FAIL conc_valids: got %b want 11", {mst_req.aw_valid, mst_req.ar_valid}); else passed++;
        next_cycle();
    endtask

    task automatic test_rule_change();
        mst_resp.ar_ready = 1'b0;
        slv_req.ar.addr   = 64'h8000_0044;
        slv_req.ar_valid  = 1'b1;
        next_cycle();
        slv_req.ar_valid  = 1'b0;
        rules[0].target   = 48'h7_0000_0000;
        @(negedge clk);
        total++; if (mst_req.ar.addr !== 48'h1_2000_0044) $display("FAIL rule_change_hold: got %h want 120000044", mst_req.ar.addr); else passed++;
        next_cycle();
        rules[0].target   = 48'h1_2000_0000;
        mst_resp.ar_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        total++; if (mst_req.ar_valid !== 1'b0) $display("FAIL rule_change_pop: got %0b want 0", mst_req.ar_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_passthrough();
        slv_req.w.data    = 64'hDEAD_BEEF_0123_4567;
        slv_req.w.strb    = 8'hA5;
        slv_req.w_valid   = 1'b1;
        slv_req.b_ready   = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.b.resp   = 2'b10;
        mst_resp.b_valid  = 1'b1;
        mst_resp.r.data   = 64'h0BAD_F00D_CAFE_0001;
        mst_resp.r_valid  = 1'b1;
        @(negedge clk);
        total++; if (mst_req.w.data !== 64'hDEAD_BEEF_0123_4567) $display("FAIL pass_w_data: got %h want deadbeef01234567", mst_req.w.data); else passed++;
        total++; if (mst_req.w.strb !== 8'hA5) $display("FAIL pass_w_strb: got %h want a5", mst_req.w.strb); else passed++;
        total++; if ({mst_req.w_valid, mst_req.b_ready} !== 2'b11) $display("FAIL pass_w_ctrl: got %b want 11", {mst_req.w_valid, mst_req.b_ready}); else passed++;
        total++; if (slv_resp.b.resp !== 2'b10) $display("FAIL pass_b_resp: got %0d want 2", slv_resp.b.resp); else passed++;
        total++; if (slv_resp.r.data !== 64'h0BAD_F00D_CAFE_0001) $display("FAIL pass_r_data: got %h want 0badf00dcafe0001", slv_resp.r.data); else passed++;
        total++; if ({slv_resp.w_ready, slv_resp.r_valid} !== 2'b11) $display("FAIL pass_resp_ctrl: got %b want 11", {slv_resp.w_ready, slv_resp.r_valid}); else passed++;
        next_cycle();
        slv_req.w_valid  = 1'b0;
        mst_resp.b_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
    endtask

`ifdef AXI_ADDR_REMAP_STATS_EN
    task automatic test_stats();
        logic [63:0] addrs [5];
        addrs = '{64'h8000_0000, 64'h4000_0000, 64'hC000_0000, 64'h5000_0000, 64'h8000_0100};
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total++; if (aw_hit_cnt !== 32'd0) $display("FAIL stats_reset: got %0d want 0", aw_hit_cnt); else passed++;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            slv_req.aw.addr  = addrs[i];
            slv_req.aw_valid = 1'b1;
            next_cycle();
        end
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        total++; if (aw_hit_cnt !== 32'd3) $display("FAIL stats_aw_hit: got %0d want 3", aw_hit_cnt); else passed++;
        total++; if (aw_miss_cnt !== 32'd2) $display("FAIL stats_aw_miss: got %0d want 2", aw_miss_cnt); else passed++;
        total++; if (ar_hit_cnt !== 32'd0) $display("FAIL stats_ar_hit: got %0d want 0", ar_hit_cnt); else passed++;
        dut.u_aw.hit_cnt_q = 32'hFFFF_FFFF;
        next_cycle();
        slv_req.aw.addr  = 64'h8000_0000;
        slv_req.aw_valid = 1'b1;
        next_cycle();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        total++; if (aw_hit_cnt !== 32'hFFFF_FFFF) $display("FAIL stats_saturate: got %h want ffffffff", aw_hit_cnt); else passed++;
        total++; if (aw_miss_cnt !== 32'd2) $display("FAIL stats_miss_stable: got %0d want 2", aw_miss_cnt); else passed++;
        next_cycle();
    endtask
`endif

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        rules[0] = '{base: 64'h8000_0000, mask: 64'hF000_0000, target: 48'h1_2000_0000};
        rules[1] = '{base: 64'h8000_0000, mask: 64'hFF00_0000, target: 48'hA_0000_0000};
        rules[2] = '{base: 64'hC000_0000, mask: 64'hF000_0000, target: 48'h3_0000_0000};
        rules[3] = '{base: 64'hFFFF_0000_0000_0000, mask: 64'hFFFF_0000_0000_0000, target: 48'h0};

        test_reset();
        test_aw_hit();
        test_ar_miss();
        test_stall();
        test_priority();
        test_back_to_back();
        test_concurrent();
        test_rule_change();
        test_passthrough();
`ifdef AXI_ADDR_REMAP_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
